// File: rtl/tff_ctrl_pkg.sv
// Shared types and defaults for the T-FF counter controller.
package tff_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH toggle flip-flops: q_next = q ^ t, async active-low clear.
module tff_bank
  import tff_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_q ^ t;
  end

  assign q = q_q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Modulo-N up/down counter controller driving a T-FF bank through its T vector.
// Optional macro TCTRL_PRESCALE_EN: advance only once every PRESCALE RUN cycles.
module tff_counter_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_up,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic PRESCALE_LEGAL = (PRESCALE >= 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             up_q, up_d;
  logic             os_q, os_d;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] t_inc, t_dec;
  logic             acc_and, acc_nor;
  logic [WIDTH-1:0] mod_m1;
  logic [WIDTH-1:0] term;
  logic             at_term;
  logic             adv;

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk (clk),
    .rst (rst),
    .t   (t),
    .q   (q)
  );

`ifdef TCTRL_PRESCALE_EN
  localparam int unsigned PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_q <= '0;
    else      pre_q <= pre_d;
  end

  assign adv = PRESCALE_LEGAL && (pre_q == PRE_MAX);
`else
  // An illegal PRESCALE freezes the count instead of running silently.
  assign adv = PRESCALE_LEGAL;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mod_q   <= '0;
      up_q    <= 1'b0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      up_q    <= up_d;
      os_q    <= os_d;
    end
  end

  // Toggle masks for +1 (all lower bits set) and -1 (all lower bits clear).
  always_comb begin
    t_inc   = '0;
    t_dec   = '0;
    acc_and = 1'b1;
    acc_nor = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      t_inc[i] = acc_and;
      t_dec[i] = acc_nor;
      acc_and  = acc_and & q[i];
      acc_nor  = acc_nor & ~q[i];
    end
  end

  assign mod_m1  = mod_q - WIDTH'(1);
  assign term    = up_q ? mod_m1 : '0;
  assign at_term = (q == term);

  assign count = q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign tc    = busy && at_term && adv;

  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    up_d    = up_q;
    os_d    = os_q;
    t       = '0;
`ifdef TCTRL_PRESCALE_EN
    pre_d   = pre_q;
`endif
    case (state_q)
      S_IDLE: begin
        t = q;
`ifdef TCTRL_PRESCALE_EN
        pre_d = '0;
`endif
        if (start && !stop) begin
          mod_d   = modulus;
          up_d    = mode_up;
          os_d    = oneshot;
          state_d = S_RUN;
          if (!mode_up) t = q ^ (modulus - WIDTH'(1));
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DONE;
        end else begin
`ifdef TCTRL_PRESCALE_EN
          pre_d = adv ? '0 : pre_q + PW'(1);
`endif
          if (adv) begin
            if (at_term) begin
              if (os_q) state_d = S_DONE;
              else      t = up_q ? q : (q ^ mod_m1);
            end else begin
              t = up_q ? t_inc : t_dec;
            end
          end
        end
      end
      S_DONE: begin
        // Count is visible unchanged during DONE; clearing on exit means IDLE always reads 0.
        t       = q;
        state_d = S_IDLE;
      end
      default: begin
        t       = q;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Scoreboard bench for tff_counter_ctrl against an arithmetic modulo-N reference model.
module tb_tff_counter_ctrl;

  localparam int W = 4;
`ifdef TCTRL_PRESCALE_EN
  localparam int P = 3;
`else
  localparam int P = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0, stop = 1'b0, mode_up = 1'b0, oneshot = 1'b0;
  logic [W-1:0] modulus = '0;
  logic [W-1:0] count;
  logic         busy, tc, done;

  tff_counter_ctrl #(.WIDTH(W), .PRESCALE(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .mode_up (mode_up),
    .oneshot (oneshot),
    .modulus (modulus),
    .count   (count),
    .busy    (busy),
    .tc      (tc),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit busy;
    bit tc;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=idle 1=run 2=done, count as plain integer.
  int m_phase = 0, m_cnt = 0, m_n = 16, m_pre = 0;
  bit m_up = 0, m_os = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int m_term();
    return m_up ? m_n - 1 : 0;
  endfunction

  task automatic push_expect();
    exp_t e;
    e.cnt  = m_cnt;
    e.busy = (m_phase == 1);
    e.done = (m_phase == 2);
    e.tc   = (m_phase == 1) && (m_cnt == m_term()) && (m_pre == P - 1);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_n = 16; m_pre = 0; m_up = 0; m_os = 0;
  endtask

  task automatic model_next(input bit s, input bit p, input bit u, input bit o, input int md);
    case (m_phase)
      0: begin
        m_cnt = 0;
        if (s && !p) begin
          m_n     = (md == 0) ? 16 : md;
          m_up    = u;
          m_os    = o;
          m_pre   = 0;
          m_phase = 1;
          m_cnt   = u ? 0 : m_n - 1;
        end
      end
      1: begin
        if (p) m_phase = 2;
        else if (m_pre == P - 1) begin
          m_pre = 0;
          if (m_cnt == m_term()) begin
            if (m_os) m_phase = 2;
            else      m_cnt = m_up ? 0 : m_n - 1;
          end else begin
            m_cnt = m_up ? m_cnt + 1 : m_cnt - 1;
          end
        end else m_pre++;
      end
      default: begin
        m_phase = 0;
        m_cnt   = 0;
      end
    endcase
  endtask

  task automatic step(input bit s, input bit p, input bit u, input bit o, input int md);
    @(posedge clk);
    #1;
    start = s; stop = p; mode_up = u; oneshot = o; modulus = W'(md);
    push_expect();
    if (rst) model_next(s, p, u, o, md);
    else     model_reset();
  endtask

  // Random noise on inputs that must be ignored while not in IDLE.
  task automatic noise_step(input bit p);
    step((m_phase != 0) ? bit'($urandom_range(0, 1)) : 1'b0, p,
         bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom_range(0, 15));
  endtask

  task automatic run_seq(input int md, input bit u, input bit o, input int cycles);
    step(1'b1, 1'b0, u, o, md);
    for (int i = 0; i < cycles; i++) noise_step(1'b0);
  endtask

  task automatic run_until_count(input int target, input int budget);
    int k;
    k = 0;
    while (!(m_phase == 1 && m_cnt == target) && k < budget) begin
      noise_step(1'b0);
      k++;
    end
    chk("reach_count", m_cnt, target);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count", int'(count), e.cnt);
      chk("busy", int'(busy), int'(e.busy));
      chk("tc", int'(tc), int'(e.tc));
      chk("done", int'(done), int'(e.done));
    end
  end

  initial begin
    model_reset();
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 0);

    run_seq(6, 1'b1, 1'b0, 16 * P);          // up free-run N=6
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0);

    run_seq(5, 1'b0, 1'b1, 8 * P);           // down oneshot N=5
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 0);

    step(1'b1, 1'b0, 1'b1, 1'b0, 10);        // stop at count=3
    run_until_count(3, 20 * P);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0);

    step(1'b1, 1'b1, 1'b1, 1'b0, 6);         // start and stop together
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0);

    run_seq(1, 1'b1, 1'b0, 6 * P);           // N=1 free-run
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_seq(1, 1'b1, 1'b1, 4 * P);           // N=1 oneshot
    run_seq(0, 1'b1, 1'b0, 20 * P);          // N=0 up wrap 15->0
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_seq(0, 1'b0, 1'b0, 20 * P);          // N=0 down wrap 0->15
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Asynchronous reset mid-RUN at count=5
    step(1'b1, 1'b0, 1'b1, 1'b0, 10);
    run_until_count(5, 20 * P);
    @(posedge clk);
    #1;
    push_expect();
    #5;
    rst = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tc", int'(tc), 0);
    model_reset();
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 0);

    for (int r = 0; r < 25; r++) begin
      int len;
      len = $urandom_range(3, 40);
      step(1'b1, 1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 15));
      for (int i = 0; i < len; i++) noise_step($urandom_range(0, 15) == 0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    end

    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
